// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: launches the external multiplier or divider,
// stalls the pipeline and issues one HILO write per instruction. Option: MULDIV_ACC_EN (madd/msub).
module muldiv_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flushE,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [63:0] hilo_i,
    output logic        mul_start,
    output logic        mul_signed,
    input  logic [63:0] product,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_abort,
    input  logic        div_done,
    input  logic [31:0] quotient,
    input  logic [31:0] remainder,
    output logic        stall_o,
    output logic        hilo_wen,
    output logic [63:0] hilo_wdata
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_ACC, S_DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      result;
    logic [63:0]      last_wdata;
    logic             suppress;
    logic             accept, mul_class, div_class, div_zero;

    // Operands go straight to the external units; only their div-by-zero status is kept here.
`ifdef MULDIV_ACC_EN
    logic [2:0] op_q;
    logic       unused_ok;
    assign unused_ok = ^src_a;
    assign mul_class = !op_type[1] || op_type[2];
`else
    logic       unused_ok;
    assign unused_ok = ^{src_a, hilo_i};
    assign mul_class = (op_type[2:1] == 2'b00);
`endif

    assign div_class = (op_type[2:1] == 2'b01);
    assign div_zero  = (src_b == 32'd0);
    assign accept    = (state == S_IDLE) && op_valid && !flushE && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (accept) begin
                if (mul_class)                  state_nx = S_MUL;
                else if (div_class && !div_zero) state_nx = S_DIV;
                else                            state_nx = S_DONE;
            end
            S_MUL: begin
                if (flushE)          state_nx = S_IDLE;
`ifdef MULDIV_ACC_EN
                else if (cnt == '0)  state_nx = op_q[2] ? S_ACC : S_DONE;
`else
                else if (cnt == '0)  state_nx = S_DONE;
`endif
            end
`ifdef MULDIV_ACC_EN
            S_ACC:   state_nx = flushE ? S_IDLE : S_DONE;
`endif
            S_DIV: begin
                if (flushE)        state_nx = S_IDLE;
                else if (div_done) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mul_start  = accept && mul_class;
        mul_signed = mul_start && !op_type[0];
        div_start  = accept && div_class && !div_zero;
        div_signed = div_start && !op_type[0];
        div_abort  = !rst && (state == S_DIV) && flushE;
        stall_o    = accept ||
                     (!rst && !flushE &&
                      (state == S_MUL || state == S_ACC || state == S_DIV));
        hilo_wen   = !rst && (state == S_DONE) && !suppress && !flushE;
        hilo_wdata = hilo_wen ? result : last_wdata;
    end

    // The captured product stays in result so ACC does not depend on the multiplier holding it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            result     <= '0;
            last_wdata <= '0;
            suppress   <= 1'b0;
`ifdef MULDIV_ACC_EN
            op_q       <= '0;
`endif
        end else begin
            if (accept) begin
                cnt      <= CNT_W'(MUL_LAT - 1);
                suppress <= !(mul_class || (div_class && !div_zero));
`ifdef MULDIV_ACC_EN
                op_q     <= op_type;
`endif
            end else if (state == S_MUL && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (state == S_MUL && cnt == '0 && !flushE)
                result <= product;
`ifdef MULDIV_ACC_EN
            if (state == S_ACC && !flushE)
                result <= op_q[1] ? (hilo_i - result) : (hilo_i + result);
`endif
            if (state == S_DIV && div_done && !flushE)
                result <= {remainder, quotient};

            if (hilo_wen)
                last_wdata <= result;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (MUL_LAT=2); covers both MULDIV_ACC_EN builds.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst, flushE, op_valid;
    logic [2:0]  op_type;
    logic [31:0] src_a, src_b;
    logic [63:0] hilo_i, product;
    logic        mul_start, mul_signed, div_start, div_signed, div_abort;
    logic        div_done;
    logic [31:0] quotient, remainder;
    logic        stall_o, hilo_wen;
    logic [63:0] hilo_wdata;

    int checks   = 0;
    int failures = 0;
    logic [63:0] last_exp;

    muldiv_ctrl #(.MUL_LAT(2), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .flushE(flushE), .op_valid(op_valid),
        .op_type(op_type), .src_a(src_a), .src_b(src_b), .hilo_i(hilo_i),
        .mul_start(mul_start), .mul_signed(mul_signed), .product(product),
        .div_start(div_start), .div_signed(div_signed), .div_abort(div_abort),
        .div_done(div_done), .quotient(quotient), .remainder(remainder),
        .stall_o(stall_o), .hilo_wen(hilo_wen), .hilo_wdata(hilo_wdata)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flushE = 1'b0; op_valid = 1'b0; op_type = 3'd0;
        src_a = '0; src_b = '0; hilo_i = '0; product = '0;
        div_done = 1'b0; quotient = '0; remainder = '0;

        // reset held for two cycles
        cyc(); cyc(); #2;
        chk("rst_stall", stall_o, 0);
        chk("rst_wen", hilo_wen, 0);
        chk("rst_mstart", mul_start, 0);
        chk("rst_dstart", div_start, 0);
        chk("rst_abort", div_abort, 0);
        chk("rst_wdata", hilo_wdata, 0);
        cyc(); rst = 1'b0; #2;
        chk("idle_stall", stall_o, 0);

        // mult 0xFFFFFFFE * 3
        cyc(); op_valid = 1; op_type = 3'd0; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
        product = 64'hDEAD_BEEF_0000_0001; #2;
        chk("mult_start", mul_start, 1);
        chk("mult_signed", mul_signed, 1);
        chk("mult_stall_T", stall_o, 1);
        chk("mult_nodiv", div_start, 0);
        cyc(); #2;
        chk("mult_stall_T1", stall_o, 1);
        chk("mult_start_once", mul_start, 0);
        cyc(); product = 64'hFFFF_FFFF_FFFF_FFFA; #2;
        chk("mult_stall_T2", stall_o, 1);
        chk("mult_nowen_T2", hilo_wen, 0);
        cyc(); product = 64'h1234; op_valid = 0; #2;
        chk("mult_stall_T3", stall_o, 0);
        chk("mult_wen", hilo_wen, 1);
        chk("mult_wdata", hilo_wdata, 64'hFFFF_FFFF_FFFF_FFFA);
        cyc(); #2;
        chk("mult_wen_off", hilo_wen, 0);
        chk("mult_wdata_hold", hilo_wdata, 64'hFFFF_FFFF_FFFF_FFFA);

        // divu 7 / 2, div_done at T+5
        cyc(); op_valid = 1; op_type = 3'd3; src_a = 32'd7; src_b = 32'd2; #2;
        chk("divu_start", div_start, 1);
        chk("divu_signed", div_signed, 0);
        chk("divu_nomul", mul_start, 0);
        chk("divu_stall_T", stall_o, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc(); #2;
            chk($sformatf("divu_stall_T%0d", i), stall_o, 1);
            chk($sformatf("divu_nowen_T%0d", i), hilo_wen, 0);
        end
        cyc(); div_done = 1; quotient = 32'd3; remainder = 32'd1; #2;
        chk("divu_stall_T5", stall_o, 1);
        cyc(); div_done = 0; quotient = 32'hFFFF_FFFF; remainder = 32'hFFFF_FFFF; op_valid = 0; #2;
        chk("divu_wen", hilo_wen, 1);
        chk("divu_wdata", hilo_wdata, 64'h0000_0001_0000_0003);
        chk("divu_stall_T6", stall_o, 0);
        cyc(); #2;
        chk("divu_wen_off", hilo_wen, 0);
        last_exp = 64'h0000_0001_0000_0003;

        // div by zero
        cyc(); op_valid = 1; op_type = 3'd2; src_a = 32'd5; src_b = 32'd0; #2;
        chk("dz_nostart", div_start, 0);
        chk("dz_stall", stall_o, 1);
        cyc(); op_valid = 0; #2;
        chk("dz_stall_off", stall_o, 0);
        chk("dz_nowen", hilo_wen, 0);
        chk("dz_wdata_hold", hilo_wdata, last_exp);
        cyc(); #2;
        chk("dz_nowen2", hilo_wen, 0);

`ifdef MULDIV_ACC_EN
        // msub: 0x10 - 0x20
        cyc(); op_valid = 1; op_type = 3'd6; hilo_i = 64'h10; product = 64'h0; #2;
        chk("msub_start", mul_start, 1);
        chk("msub_signed", mul_signed, 1);
        cyc(); #2;
        cyc(); product = 64'h20; #2;
        chk("msub_stall_T2", stall_o, 1);
        cyc(); product = 64'h0; #2;
        chk("msub_stall_acc", stall_o, 1);
        chk("msub_nowen_acc", hilo_wen, 0);
        cyc(); op_valid = 0; #2;
        chk("msub_wen", hilo_wen, 1);
        chk("msub_wdata", hilo_wdata, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("msub_stall_done", stall_o, 0);
        last_exp = 64'hFFFF_FFFF_FFFF_FFF0;
        cyc(); #2;
        chk("msub_wen_off", hilo_wen, 0);
`else
        // msub as no-op when accumulate is not built
        cyc(); op_valid = 1; op_type = 3'd6; hilo_i = 64'h10; #2;
        chk("msub_nop_nostart", mul_start, 0);
        chk("msub_nop_stall", stall_o, 1);
        cyc(); op_valid = 0; #2;
        chk("msub_nop_stall_off", stall_o, 0);
        chk("msub_nop_nowen", hilo_wen, 0);
`endif

        // flush during divu at T+2, late div_done ignored
        cyc(); op_valid = 1; op_type = 3'd3; src_a = 32'd9; src_b = 32'd4; #2;
        chk("fl_div_start", div_start, 1);
        cyc(); #2;
        chk("fl_stall_T1", stall_o, 1);
        chk("fl_noabort_T1", div_abort, 0);
        cyc(); flushE = 1; #2;
        chk("fl_abort", div_abort, 1);
        chk("fl_stall_drop", stall_o, 0);
        cyc(); flushE = 0; op_valid = 0; div_done = 1; quotient = 32'd2; remainder = 32'd1; #2;
        chk("fl_abort_once", div_abort, 0);
        chk("fl_idle_stall", stall_o, 0);
        chk("fl_late_nowen", hilo_wen, 0);
        cyc(); div_done = 0; #2;
        chk("fl_nowen2", hilo_wen, 0);
        chk("fl_wdata_hold", hilo_wdata, last_exp);

        // flush in IDLE blocks accept
        cyc(); op_valid = 1; op_type = 3'd0; flushE = 1; #2;
        chk("flidle_stall", stall_o, 0);
        chk("flidle_nostart", mul_start, 0);
        cyc(); op_valid = 0; flushE = 0; #2;
        chk("flidle_stall2", stall_o, 0);

        // multu flushed in DONE
        cyc(); op_valid = 1; op_type = 3'd1; src_a = 32'd2; src_b = 32'd3; #2;
        chk("multu_start", mul_start, 1);
        chk("multu_unsigned", mul_signed, 0);
        cyc(); #2;
        cyc(); product = 64'h6; #2;
        cyc(); op_valid = 0; flushE = 1; #2;
        chk("fldone_nowen", hilo_wen, 0);
        chk("fldone_wdata", hilo_wdata, last_exp);
        cyc(); flushE = 0; #2;
        chk("fldone_nowen2", hilo_wen, 0);

        // reset in the middle of a mult
        cyc(); op_valid = 1; op_type = 3'd0; product = 64'h77; #2;
        chk("rmid_start", mul_start, 1);
        cyc(); rst = 1; #2;
        chk("rmid_stall", stall_o, 0);
        cyc(); rst = 0; op_valid = 0; #2;
        chk("rmid_idle_stall", stall_o, 0);
        chk("rmid_wdata", hilo_wdata, 0);
        cyc(); #2;
        chk("rmid_nowen", hilo_wen, 0);
        cyc(); #2;
        chk("rmid_nowen2", hilo_wen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
